// File: rtl/hazard_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_pkg: shared types and defaults for the fetch/hazard sequencer |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        DROP = 1'b1
    } fh_state_t;

    localparam int REGW_DEFAULT = 5;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_use_detect: flags a Decode source that needs a load in Execute  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module load_use_detect
    import hazard_pkg::*;
#(
    parameter int REGW = REGW_DEFAULT
) (
    input  logic [REGW-1:0] rs1_d,
    input  logic [REGW-1:0] rs2_d,
    input  logic [REGW-1:0] rd_e,
    input  logic            reg_write_e,
    input  logic            load_e,
    output logic            hazard
);

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign hazard = load_e & reg_write_e & (rd_e != '0) &
                    ((rd_e == rs1_d) | (rd_e == rs2_d));

endmodule : load_use_detect
`default_nettype wire

// File: rtl/fetch_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_hazard_ctrl: stall/flush sequencer for the RV32 five-stage     |
// | pipeline. Optional HAZARD_PERF_CNT_EN adds stall/flush counters.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int REGW    = REGW_DEFAULT,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            imemReady,
    input  logic [REGW-1:0] Rs1D,
    input  logic [REGW-1:0] Rs2D,
    input  logic [REGW-1:0] RdE,
    input  logic            RegWriteE,
    input  logic            LoadE,
    input  logic            mdBusyE,
    input  logic            PCSrcE,
    output logic            StallF,
    output logic            StallD,
    output logic            StallE,
    output logic            FlushD,
    output logic            FlushE,
`ifdef HAZARD_PERF_CNT_EN
    output logic [XLEN-1:0] stallCycles,
    output logic [XLEN-1:0] flushEvents,
`endif
    output logic            imemTimeout
);

    localparam int               WAITW     = $clog2(TIMEOUT + 1);
    localparam logic [WAITW-1:0] WAIT_MAX  = WAITW'(TIMEOUT);
    localparam logic [WAITW-1:0] WAIT_LAST = WAITW'(TIMEOUT - 1);

    fh_state_t        state;
    logic [WAITW-1:0] wait_cnt;
    logic             load_use;

    load_use_detect #(
        .REGW (REGW)
    ) u_load_use (
        .rs1_d       (Rs1D),
        .rs2_d       (Rs2D),
        .rd_e        (RdE),
        .reg_write_e (RegWriteE),
        .load_e      (LoadE),
        .hazard      (load_use)
    );

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (!reset) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (state == DROP) begin
            StallF = 1'b1;
            FlushD = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (mdBusyE) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
        end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end else if (!imemReady) begin
            StallF = 1'b1;
            FlushD = 1'b1;
        end
    end

    // Fires on the wait cycle that brings the count to TIMEOUT; saturation blocks repeats
    assign imemTimeout = reset & ~imemReady & (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                RUN:     if (PCSrcE && !imemReady) state <= DROP;
                DROP:    if (imemReady) state <= RUN;
                default: state <= RUN;
            endcase
            if (imemReady) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCycles <= '0;
            flushEvents <= '0;
        end else begin
            stallCycles <= stallCycles + {{(XLEN-1){1'b0}}, StallF};
            flushEvents <= flushEvents + {{(XLEN-1){1'b0}}, FlushE};
        end
    end
`else
    if (XLEN > 0) begin : g_no_perf_cnt
    end
`endif

endmodule : fetch_hazard_ctrl
`default_nettype wire

// File: tb/tb_fetch_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_hazard_ctrl: directed + random bench against a rule model   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_fetch_hazard_ctrl;

    localparam int XLEN = 32;
    localparam int REGW = 5;
    localparam int TOUT = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            imemReady;
    logic [REGW-1:0] Rs1D, Rs2D, RdE;
    logic            RegWriteE, LoadE, mdBusyE, PCSrcE;
    logic            StallF, StallD, StallE, FlushD, FlushE, imemTimeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [XLEN-1:0] stallCycles, flushEvents;
`endif

    fetch_hazard_ctrl #(
        .XLEN    (XLEN),
        .REGW    (REGW),
        .TIMEOUT (TOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imemReady   (imemReady),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .RdE         (RdE),
        .RegWriteE   (RegWriteE),
        .LoadE       (LoadE),
        .mdBusyE     (mdBusyE),
        .PCSrcE      (PCSrcE),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
`ifdef HAZARD_PERF_CNT_EN
        .stallCycles (stallCycles),
        .flushEvents (flushEvents),
`endif
        .imemTimeout (imemTimeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: are we discarding a stale fetch, how many back-to-back waits so far
    bit          m_dropping = 1'b0;
    int          m_waits    = 0;
    logic [31:0] m_stalls   = '0;
    logic [31:0] m_flushes  = '0;
    bit          last_to;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model on the edge
    task automatic cyc(input bit rst_n, input bit rdy, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input bit rw, input bit ld, input bit md, input bit pc);
        bit sf, sd, se, fd, fe, to, hazard;
        @(negedge clk);
        reset = rst_n; imemReady = rdy; Rs1D = rs1; Rs2D = rs2; RdE = rd;
        RegWriteE = rw; LoadE = ld; mdBusyE = md; PCSrcE = pc;
        #1;
        hazard = ld && rw && (rd != 0) && (rd == rs1 || rd == rs2);
        {sf, sd, se, fd, fe} = 5'b0;
        if (!rst_n)          begin fd = 1; fe = 1; end
        else if (m_dropping) begin sf = 1; fd = 1; end
        else if (pc)         begin fd = 1; fe = 1; end
        else if (md)         begin sf = 1; sd = 1; se = 1; end
        else if (hazard)     begin sf = 1; sd = 1; fe = 1; end
        else if (!rdy)       begin sf = 1; fd = 1; end
        to = rst_n && !rdy && (m_waits + 1 == TOUT);
        check("outputs{SF,SD,SE,FD,FE,TO}", {58'd0, StallF, StallD, StallE, FlushD, FlushE, imemTimeout},
              {58'd0, sf, sd, se, fd, fe, to});
        check("flushd_stalld_exclusive", {63'd0, StallD & FlushD}, 64'd0);
`ifdef HAZARD_PERF_CNT_EN
        check("stallCycles", {32'd0, stallCycles}, {32'd0, m_stalls});
        check("flushEvents", {32'd0, flushEvents}, {32'd0, m_flushes});
`endif
        last_to = imemTimeout;
        @(posedge clk);
        if (!rst_n) begin
            m_dropping = 0; m_waits = 0; m_stalls = '0; m_flushes = '0;
        end else begin
            if (m_dropping) m_dropping = !rdy;
            else            m_dropping = pc && !rdy;
            m_waits   = rdy ? 0 : m_waits + 1;
            m_stalls  = m_stalls + 32'(sf);
            m_flushes = m_flushes + 32'(fe);
        end
    endtask

    initial begin
        int pulses, pulse_at;
        reset = 0; imemReady = 1; Rs1D = 0; Rs2D = 0; RdE = 0;
        RegWriteE = 0; LoadE = 0; mdBusyE = 0; PCSrcE = 0;

        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);

        // load x5 then add x6,x5,x1: one stall cycle, then the bubble sits in Execute
        cyc(1, 1, 5, 1, 5, 1, 1, 0, 0);
        cyc(1, 1, 5, 1, 0, 0, 0, 0, 0);
        // load to x0 never stalls
        cyc(1, 1, 0, 0, 0, 1, 1, 0, 0);

        // branch with fetch outstanding: three DROP cycles, then RUN
        cyc(1, 0, 1, 2, 3, 1, 0, 0, 1);
        cyc(1, 0, 1, 2, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 2, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 2, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 2, 0, 0, 0, 0, 0);

        // multi-cycle busy masks a pending load-use, which then applies
        for (int i = 0; i < 4; i++) cyc(1, 1, 7, 2, 7, 1, 1, 1, 0);
        cyc(1, 1, 7, 2, 7, 1, 1, 0, 0);
        cyc(1, 1, 7, 2, 0, 0, 0, 0, 0);

        // timeout: exactly one pulse, on the third wait cycle
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        pulses = 0; pulse_at = -1;
        for (int i = 1; i <= 10; i++) begin
            cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
            if (last_to) begin pulses++; pulse_at = i; end
        end
        check("timeout_pulse_count", 64'(pulses), 64'd1);
        check("timeout_pulse_cycle", 64'(pulse_at), 64'(TOUT));

        // reset while dropping a stale fetch
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 199) != 0, $urandom_range(0, 9) < 7,
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fetch_hazard_ctrl
`default_nettype wire
